// File: rtl/trigger_edge_qualifier.sv
// Per-channel trigger front end: 2-flop sync, glitch filter, edge select, holdoff.
// O_trigger registers 3 edges after raw is first sampled (+1 per min_width beyond 1); no backpressure.
module trigger_edge_qualifier #(
    parameter int pNUM_TRIGGERS = 4,
    parameter int pFILTER_WIDTH = 8
) (
    input  logic                                   adc_clk,
    input  logic                                   reset,
    input  logic                                   I_arm,
    input  logic [pNUM_TRIGGERS-1:0]               I_trigger_raw,
    input  logic [2*pNUM_TRIGGERS-1:0]             I_edge_mode,
    input  logic [pNUM_TRIGGERS*pFILTER_WIDTH-1:0] I_min_width,
    input  logic [pNUM_TRIGGERS*pFILTER_WIDTH-1:0] I_holdoff,
    output logic [pNUM_TRIGGERS-1:0]               O_trigger,
    output logic [pNUM_TRIGGERS-1:0]               O_filtered
);

    localparam logic [pFILTER_WIDTH-1:0] ONE = pFILTER_WIDTH'(1);

    for (genvar g = 0; g < pNUM_TRIGGERS; g++) begin : g_ch
        logic                     sync1_q, sync2_q;
        logic                     filt_q, filt_d, filt_prev_q;
        logic                     trig_q, trig_d;
        logic [pFILTER_WIDTH-1:0] fcnt_q, fcnt_d;
        logic [pFILTER_WIDTH-1:0] hcnt_q, hcnt_d;
        logic [1:0]               mode;
        logic [pFILTER_WIDTH-1:0] min_w, hold;
        logic                     rise, fall, ev;

        assign mode  = I_edge_mode[2*g +: 2];
        assign min_w = I_min_width[g*pFILTER_WIDTH +: pFILTER_WIDTH];
        assign hold  = I_holdoff[g*pFILTER_WIDTH +: pFILTER_WIDTH];
        assign rise  = filt_q & ~filt_prev_q;
        assign fall  = ~filt_q & filt_prev_q;

        // A stretched fcnt (min_width lowered mid-count) flips filt immediately.
        always_comb begin
            filt_d = filt_q;
            fcnt_d = '0;
            if (sync2_q != filt_q) begin
                if (min_w <= ONE || fcnt_q >= min_w - ONE) begin
                    filt_d = sync2_q;
                end else begin
                    fcnt_d = fcnt_q + ONE;
                end
            end
        end

        always_comb begin
            ev = 1'b0;
            case (mode)
                2'b00:   ev = rise;
                2'b01:   ev = fall;
                2'b10:   ev = rise | fall;
                default: ev = 1'b0;
            endcase
        end

        always_comb begin
            trig_d = 1'b0;
            hcnt_d = hcnt_q;
            if (!I_arm) begin
                hcnt_d = '0;
            end else if (mode == 2'b11) begin
                trig_d = filt_q;
                hcnt_d = '0;
            end else if (ev && hcnt_q == '0) begin
                trig_d = 1'b1;
                hcnt_d = hold;
            end else if (hcnt_q != '0) begin
                hcnt_d = hcnt_q - ONE;
            end
        end

        always_ff @(posedge adc_clk or posedge reset) begin
            if (reset) begin
                sync1_q     <= 1'b0;
                sync2_q     <= 1'b0;
                filt_q      <= 1'b0;
                filt_prev_q <= 1'b0;
                fcnt_q      <= '0;
                hcnt_q      <= '0;
                trig_q      <= 1'b0;
            end else begin
                sync1_q     <= I_trigger_raw[g];
                sync2_q     <= sync1_q;
                filt_q      <= filt_d;
                filt_prev_q <= filt_q;
                fcnt_q      <= fcnt_d;
                hcnt_q      <= hcnt_d;
                trig_q      <= trig_d;
            end
        end

        assign O_trigger[g]  = trig_q;
        assign O_filtered[g] = filt_q;
    end

endmodule

// File: tb/tb_trigger_edge_qualifier.sv
// Bench for trigger_edge_qualifier: vector table plus hand sequences, pulses checked
// against a queue of expected (channel, cycle) entries.
module tb_trigger_edge_qualifier;

    localparam int NT = 4;
    localparam int FW = 8;

    logic             adc_clk = 1'b0;
    logic             reset;
    logic             I_arm;
    logic [NT-1:0]    I_trigger_raw;
    logic [2*NT-1:0]  I_edge_mode;
    logic [NT*FW-1:0] I_min_width;
    logic [NT*FW-1:0] I_holdoff;
    logic [NT-1:0]    O_trigger;
    logic [NT-1:0]    O_filtered;

    trigger_edge_qualifier #(.pNUM_TRIGGERS(NT), .pFILTER_WIDTH(FW)) dut (
        .adc_clk       (adc_clk),
        .reset         (reset),
        .I_arm         (I_arm),
        .I_trigger_raw (I_trigger_raw),
        .I_edge_mode   (I_edge_mode),
        .I_min_width   (I_min_width),
        .I_holdoff     (I_holdoff),
        .O_trigger     (O_trigger),
        .O_filtered    (O_filtered)
    );

    always #5 adc_clk = ~adc_clk;

    typedef struct {
        int ch;
        int cyc;
    } exp_t;

    typedef struct {
        int       ch;
        logic [1:0] mode;
        int       mw;
        int       ho;
        int       len;
        bit       exp_rise;
        bit       exp_fall;
        bit       exp_filt;
    } vec_t;

    exp_t       exp_q[$];
    vec_t       vt[8];
    int         cyc;
    int         vectors;
    int         fails;
    logic [NT-1:0] lvl_mask;

    task automatic check1(input string name, input logic got, input logic req);
        vectors++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %b, required %b", name, cyc, got, req);
        end
    endtask

    task automatic push_exp(input int ch, input int at);
        exp_t e;
        e.ch  = ch;
        e.cyc = at;
        exp_q.push_back(e);
    endtask

    task automatic check_pulses();
        int found;
        for (int c = 0; c < NT; c++) begin
            if (!lvl_mask[c] && O_trigger[c] === 1'b1) begin
                found = -1;
                for (int j = 0; j < exp_q.size(); j++)
                    if (found < 0 && exp_q[j].ch == c && exp_q[j].cyc == cyc) found = j;
                vectors++;
                if (found >= 0) begin
                    exp_q.delete(found);
                end else begin
                    fails++;
                    $display("FAIL pulse ch%0d at cycle %0d: got O_trigger=1, required 0", c, cyc);
                end
            end
        end
        for (int j = exp_q.size() - 1; j >= 0; j--) begin
            if (exp_q[j].cyc <= cyc) begin
                vectors++;
                fails++;
                $display("FAIL pulse ch%0d at cycle %0d: got 0, required O_trigger=1",
                         exp_q[j].ch, exp_q[j].cyc);
                exp_q.delete(j);
            end
        end
    endtask

    task automatic tick();
        @(posedge adc_clk);
        @(negedge adc_clk);
        cyc++;
        check_pulses();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_cfg(input int ch, input logic [1:0] mode, input int mw, input int ho);
        I_edge_mode[2*ch +: 2]  = mode;
        I_min_width[ch*FW +: FW] = mw[FW-1:0];
        I_holdoff[ch*FW +: FW]   = ho[FW-1:0];
    endtask

    task automatic run_vec(input vec_t v);
        int k;
        int ext;
        ext = (v.mw > 1) ? v.mw - 1 : 0;
        set_cfg(v.ch, v.mode, v.mw, v.ho);
        ticks(5);
        k = cyc + 1;
        I_trigger_raw[v.ch] = 1'b1;
        if (v.exp_rise) push_exp(v.ch, k + 3 + ext);
        ticks(v.len);
        I_trigger_raw[v.ch] = 1'b0;
        if (v.exp_fall) push_exp(v.ch, k + v.len + 3 + ext);
        ticks(2);
        check1("filtered_level", O_filtered[v.ch], v.exp_filt);
        ticks(30);
        set_cfg(v.ch, 2'b00, 0, 0);
    endtask

    initial begin
        int k;
        vectors  = 0;
        fails    = 0;
        cyc      = 0;
        lvl_mask = '0;
        reset         = 1'b1;
        I_arm         = 1'b1;
        I_trigger_raw = '0;
        I_edge_mode   = '0;
        I_min_width   = '0;
        I_holdoff     = '0;

        //          ch mode  mw ho len rise fall filt
        vt[0] = '{0, 2'b00, 0, 0, 20, 1'b1, 1'b0, 1'b1};
        vt[1] = '{0, 2'b00, 5, 0,  4, 1'b0, 1'b0, 1'b0};
        vt[2] = '{0, 2'b00, 5, 0,  5, 1'b1, 1'b0, 1'b1};
        vt[3] = '{1, 2'b01, 1, 0,  6, 1'b0, 1'b1, 1'b1};
        vt[4] = '{3, 2'b10, 2, 0,  3, 1'b1, 1'b1, 1'b1};
        vt[5] = '{3, 2'b10, 0, 8,  5, 1'b1, 1'b0, 1'b1};
        vt[6] = '{2, 2'b10, 0, 4,  5, 1'b1, 1'b1, 1'b1};
        vt[7] = '{1, 2'b00, 3, 0,  2, 1'b0, 1'b0, 1'b0};

        #1;
        for (int c = 0; c < NT; c++) begin
            check1("reset_trigger", O_trigger[c], 1'b0);
            check1("reset_filtered", O_filtered[c], 1'b0);
        end
        ticks(2);
        reset = 1'b0;
        ticks(5);

        for (int i = 0; i < 8; i++) run_vec(vt[i]);

        // Both-edge mode, holdoff 10, toggle every 3 cycles: events 1, 5, 9 pass.
        set_cfg(0, 2'b10, 0, 10);
        ticks(5);
        for (int t = 0; t < 10; t++) begin
            k = cyc + 1;
            I_trigger_raw[0] = ~I_trigger_raw[0];
            if (t == 0 || t == 4 || t == 8) push_exp(0, k + 3);
            ticks(3);
        end
        ticks(30);
        set_cfg(0, 2'b00, 0, 0);

        // ch1 falling edge and ch2 level mode change on the same cycle.
        set_cfg(1, 2'b01, 0, 0);
        set_cfg(2, 2'b11, 0, 0);
        lvl_mask[2] = 1'b1;
        I_trigger_raw[1] = 1'b1;
        ticks(10);
        k = cyc + 1;
        I_trigger_raw[1] = 1'b0;
        I_trigger_raw[2] = 1'b1;
        push_exp(1, k + 3);
        while (cyc < k + 2) tick();
        check1("level_before", O_trigger[2], 1'b0);
        tick();
        check1("level_rise", O_trigger[2], 1'b1);
        ticks(5);
        check1("level_held", O_trigger[2], 1'b1);
        k = cyc + 1;
        I_trigger_raw[2] = 1'b0;
        while (cyc < k + 2) tick();
        check1("level_still", O_trigger[2], 1'b1);
        tick();
        check1("level_fall", O_trigger[2], 1'b0);
        ticks(10);
        lvl_mask[2] = 1'b0;
        set_cfg(1, 2'b00, 0, 0);
        set_cfg(2, 2'b00, 0, 0);

        // Edge while disarmed is lost; next edge after arming pulses.
        I_arm = 1'b0;
        I_trigger_raw[0] = 1'b1;
        ticks(10);
        I_arm = 1'b1;
        ticks(5);
        I_trigger_raw[0] = 1'b0;
        ticks(5);
        k = cyc + 1;
        I_trigger_raw[0] = 1'b1;
        push_exp(0, k + 3);
        ticks(10);

        // Arm rising on the same cycle the edge is qualified.
        I_trigger_raw[0] = 1'b0;
        ticks(5);
        I_arm = 1'b0;
        ticks(2);
        k = cyc + 1;
        I_trigger_raw[0] = 1'b1;
        while (cyc < k + 2) tick();
        I_arm = 1'b1;
        push_exp(0, k + 3);
        ticks(8);

        // Reset during the pulse of a long holdoff.
        I_trigger_raw[0] = 1'b0;
        ticks(5);
        set_cfg(0, 2'b00, 0, 20);
        ticks(2);
        k = cyc + 1;
        I_trigger_raw[0] = 1'b1;
        push_exp(0, k + 3);
        while (cyc < k + 3) tick();
        reset = 1'b1;
        #1;
        check1("reset_async_trigger", O_trigger[0], 1'b0);
        check1("reset_async_filtered", O_filtered[0], 1'b0);
        ticks(3);
        reset = 1'b0;
        push_exp(0, cyc + 4);
        ticks(10);
        check1("post_reset_filtered", O_filtered[0], 1'b1);
        I_trigger_raw[0] = 1'b0;
        ticks(30);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
